// File: rtl/block_operand_stack.sv
// -----------------------------------------------------------------------------
// block_operand_stack
// Operand stack feeding the ALU ops block. TOS and NOS are held in registers;
// deeper entries live in a synchronous single-port RAM. POP/REPLACE that expose
// a RAM-resident entry refill NOS in one extra (BUSY) cycle.
// Optional feature macro: STACK_PEEK_EN (adds PEEK_IDX / PEEK_OUT).
// -----------------------------------------------------------------------------
module block_operand_stack #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 12,
   parameter int ULA_WIDTH   = 24,
   parameter int STACK_DEPTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  CMD_VALID,
   input  logic [2:0]            CMD_OP,
   input  logic [ULA_WIDTH-1:0]  DATA_IN,
   input  logic                  CLR_ERR,
`ifdef STACK_PEEK_EN
   input  logic [ADDR_WIDTH-1:0] PEEK_IDX,
   output logic [DATA_WIDTH-1:0] PEEK_OUT,
`endif
   output logic [DATA_WIDTH-1:0] TOS_OUT,
   output logic [DATA_WIDTH-1:0] NOS_OUT,
   output logic [ADDR_WIDTH-1:0] SP_OUT,
   output logic                  EMPTY,
   output logic                  FULL,
   output logic                  BUSY,
   output logic                  ERR_OVERFLOW,
   output logic                  ERR_UNDERFLOW
);

   // RAM only ever holds entries 0 .. STACK_DEPTH-3, so this width is ample.
   localparam int RAM_AW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [ADDR_WIDTH-1:0] ZERO_C  = '0;
   localparam logic [ADDR_WIDTH-1:0] ONE_C   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] TWO_C   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] THREE_C = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(STACK_DEPTH);

   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPLACE = 3'b011;
   localparam logic [2:0] OP_DUP     = 3'b100;
   localparam logic [2:0] OP_SWAP    = 3'b101;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   tos_q, tos_d;
   logic [DATA_WIDTH-1:0]   nos_q, nos_d;
   logic [ADDR_WIDTH-1:0]   count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic                    set_ovf, set_unf;
   logic                    refill_start;

   // RAM port signals
   logic [DATA_WIDTH-1:0]   mem [STACK_DEPTH];
   logic [DATA_WIDTH-1:0]   rd_q;
   logic                    ram_we;
   logic [DATA_WIDTH-1:0]   ram_wdata;
   logic [RAM_AW-1:0]       ram_wr_addr;
   logic [RAM_AW-1:0]       ram_rd_addr;
   logic [RAM_AW-1:0]       ram_addr;

   // Only the low DATA_WIDTH bits of an ALU result are stored.
   generate
      if (ULA_WIDTH > DATA_WIDTH) begin : g_ula_trim
         logic unused_ula_bits;
         assign unused_ula_bits = ^DATA_IN[ULA_WIDTH-1:DATA_WIDTH];
      end
   endgenerate

   // Command decode and datapath next-state; commands only act in IDLE.
   always_comb begin
      tos_d        = tos_q;
      nos_d        = nos_q;
      count_d      = count_q;
      set_ovf      = 1'b0;
      set_unf      = 1'b0;
      refill_start = 1'b0;
      ram_we       = 1'b0;
      ram_wdata    = nos_q;
      ram_wr_addr  = RAM_AW'(count_q - TWO_C);
      ram_rd_addr  = RAM_AW'(count_q - THREE_C);

      if (state_q == ST_REFILL) begin
         // Read issued in the accepting cycle is now in the RAM output register.
         nos_d = rd_q;
      end else if (CMD_VALID) begin
         case (CMD_OP)
            OP_PUSH, OP_DUP: begin
               if (count_q == DEPTH_C) begin
                  set_ovf = 1'b1;
               end else begin
                  // Old NOS spills to RAM only when it was a valid entry.
                  ram_we  = (count_q >= TWO_C);
                  nos_d   = tos_q;
                  tos_d   = (CMD_OP == OP_PUSH) ? DATA_IN[DATA_WIDTH-1:0] : tos_q;
                  count_d = count_q + ONE_C;
               end
            end
            OP_POP: begin
               if (count_q == ZERO_C) begin
                  set_unf = 1'b1;
               end else begin
                  tos_d   = nos_q;
                  count_d = count_q - ONE_C;
                  if (count_q >= THREE_C) refill_start = 1'b1;
                  else                    nos_d = '0;
               end
            end
            OP_REPLACE: begin
               if (count_q < TWO_C) begin
                  set_unf = 1'b1;
               end else begin
                  tos_d   = DATA_IN[DATA_WIDTH-1:0];
                  count_d = count_q - ONE_C;
                  if (count_q >= THREE_C) refill_start = 1'b1;
                  else                    nos_d = '0;
               end
            end
            OP_SWAP: begin
               if (count_q < TWO_C) begin
                  set_unf = 1'b1;
               end else begin
                  tos_d = nos_q;
                  nos_d = tos_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky error flags: a new error beats a simultaneous clear.
   always_comb begin
      ovf_d = set_ovf | (ovf_q & ~CLR_ERR);
      unf_d = set_unf | (unf_q & ~CLR_ERR);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state: a refill lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (refill_start) state_d = ST_REFILL;
         ST_REFILL: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: BUSY is combinational from state.
   always_comb begin
      BUSY = (state_q == ST_REFILL);
   end

   // Datapath and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tos_q   <= '0;
         nos_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef STACK_PEEK_EN
   logic [DATA_WIDTH-1:0] peek_q, peek_d;
   logic                  peek_ram_q, peek_ram_d;
   logic                  peek_port_free;
   logic [RAM_AW-1:0]     peek_addr;

   assign peek_port_free = (state_q == ST_IDLE) && !CMD_VALID;
   assign peek_addr      = RAM_AW'(count_q - ONE_C - PEEK_IDX);

   // When a RAM peek was issued last cycle, the RAM output register is the answer.
   assign PEEK_OUT = peek_ram_q ? rd_q : peek_q;

   // Peek selection; RAM-resident entries only when the port is otherwise idle.
   always_comb begin
      peek_d     = PEEK_OUT;
      peek_ram_d = 1'b0;
      if (PEEK_IDX >= count_q)     peek_d = '0;
      else if (PEEK_IDX == ZERO_C) peek_d = tos_q;
      else if (PEEK_IDX == ONE_C)  peek_d = nos_q;
      else if (peek_port_free)     peek_ram_d = 1'b1;
   end

   // Peek output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         peek_q     <= '0;
         peek_ram_q <= 1'b0;
      end else begin
         peek_q     <= peek_d;
         peek_ram_q <= peek_ram_d;
      end
   end

   // Single RAM address: write, then refill read, then peek read.
   always_comb begin
      if (ram_we)            ram_addr = ram_wr_addr;
      else if (refill_start) ram_addr = ram_rd_addr;
      else                   ram_addr = peek_addr;
   end
`else
   // Single RAM address: write has priority over the refill read.
   always_comb begin
      ram_addr = ram_we ? ram_wr_addr : ram_rd_addr;
   end
`endif

   // Single-port RAM with registered read; contents are never reset.
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_q <= mem[ram_addr];
   end

   assign TOS_OUT       = tos_q;
   assign NOS_OUT       = nos_q;
   assign SP_OUT        = count_q;
   assign EMPTY         = (count_q == ZERO_C);
   assign FULL          = (count_q == DEPTH_C);
   assign ERR_OVERFLOW  = ovf_q;
   assign ERR_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_block_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_block_operand_stack
// Scoreboard bench: the driver updates a queue-based stack model and pushes the
// expected post-edge outputs; a monitor pops and compares 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_block_operand_stack;
   localparam int DW    = 8;
   localparam int AW    = 12;
   localparam int UW    = 24;
   localparam int DEPTH = 64;

   localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010,
                          REPL = 3'b011, DUP = 3'b100, SWAP = 3'b101;

   logic          clk = 1'b0;
   logic          rst;
   logic          CMD_VALID;
   logic [2:0]    CMD_OP;
   logic [UW-1:0] DATA_IN;
   logic          CLR_ERR;
   logic [DW-1:0] TOS_OUT, NOS_OUT;
   logic [AW-1:0] SP_OUT;
   logic          EMPTY, FULL, BUSY, ERR_OVERFLOW, ERR_UNDERFLOW;
`ifdef STACK_PEEK_EN
   logic [AW-1:0] PEEK_IDX = '0;
   logic [DW-1:0] PEEK_OUT;
`endif

   always #5 clk = ~clk;

   block_operand_stack #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ULA_WIDTH(UW), .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP),
      .DATA_IN(DATA_IN), .CLR_ERR(CLR_ERR),
`ifdef STACK_PEEK_EN
      .PEEK_IDX(PEEK_IDX), .PEEK_OUT(PEEK_OUT),
`endif
      .TOS_OUT(TOS_OUT), .NOS_OUT(NOS_OUT), .SP_OUT(SP_OUT), .EMPTY(EMPTY),
      .FULL(FULL), .BUSY(BUSY), .ERR_OVERFLOW(ERR_OVERFLOW),
      .ERR_UNDERFLOW(ERR_UNDERFLOW)
   );

   typedef struct {
      string         name;
      logic [DW-1:0] tos;
      logic [DW-1:0] nos;
      bit            nos_chk;
      logic [AW-1:0] sp;
      bit            empty, full, busy, ovf, unf;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;

   // Reference model: the stack as a plain list, bottom at index 0.
   int unsigned mstk[$];
   bit          mbusy = 0, movf = 0, munf = 0;

   // Drive one cycle, advance the model, queue the expected post-edge outputs.
   task automatic cyc(input string nm, input bit v, input logic [2:0] op,
                      input logic [UW-1:0] d, input bit clr, input bit r);
      exp_t        e;
      bit          so, su, nb;
      int          n;
      int unsigned t;
      rst = r; CMD_VALID = v; CMD_OP = op; DATA_IN = d; CLR_ERR = clr;
      so = 0; su = 0; nb = 0;
      if (r) begin
         mstk.delete(); mbusy = 0; movf = 0; munf = 0;
      end else begin
         n = mstk.size();
         if (v && !mbusy) begin
            case (op)
               PUSH, DUP: begin
                  if (n == DEPTH) so = 1;
                  else if (op == PUSH) mstk.push_back(int'(d[7:0]));
                  else mstk.push_back(n > 0 ? mstk[n-1] : 0);
               end
               POP: begin
                  if (n == 0) su = 1;
                  else begin void'(mstk.pop_back()); nb = (n >= 3); end
               end
               REPL: begin
                  if (n < 2) su = 1;
                  else begin
                     void'(mstk.pop_back()); void'(mstk.pop_back());
                     mstk.push_back(int'(d[7:0])); nb = (n >= 3);
                  end
               end
               SWAP: begin
                  if (n < 2) su = 1;
                  else begin t = mstk[n-1]; mstk[n-1] = mstk[n-2]; mstk[n-2] = t; end
               end
               default: ;
            endcase
         end
         movf  = so | (movf & !clr);
         munf  = su | (munf & !clr);
         mbusy = nb;
      end
      n         = mstk.size();
      e.name    = nm;
      e.tos     = (n >= 1) ? DW'(mstk[n-1]) : '0;
      e.nos     = (n >= 2) ? DW'(mstk[n-2]) : '0;
      e.nos_chk = !mbusy;
      e.sp      = AW'(n);
      e.empty   = (n == 0);
      e.full    = (n == DEPTH);
      e.busy    = mbusy;
      e.ovf     = movf;
      e.unf     = munf;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one comparison per clock edge that has a queued expectation.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks++;
         if (TOS_OUT !== mon_e.tos || SP_OUT !== mon_e.sp || EMPTY !== mon_e.empty ||
             FULL !== mon_e.full || BUSY !== mon_e.busy || ERR_OVERFLOW !== mon_e.ovf ||
             ERR_UNDERFLOW !== mon_e.unf || (mon_e.nos_chk && NOS_OUT !== mon_e.nos)) begin
            errors++;
            $display("FAIL %s: got tos=%h nos=%h sp=%0d e=%b f=%b b=%b ovf=%b unf=%b; required tos=%h nos=%h(chk=%b) sp=%0d e=%b f=%b b=%b ovf=%b unf=%b",
                     mon_e.name, TOS_OUT, NOS_OUT, SP_OUT, EMPTY, FULL, BUSY,
                     ERR_OVERFLOW, ERR_UNDERFLOW, mon_e.tos, mon_e.nos, mon_e.nos_chk,
                     mon_e.sp, mon_e.empty, mon_e.full, mon_e.busy, mon_e.ovf, mon_e.unf);
         end else begin
            $display("ok %s: tos=%h nos=%h sp=%0d busy=%b ovf=%b unf=%b",
                     mon_e.name, TOS_OUT, NOS_OUT, SP_OUT, BUSY, ERR_OVERFLOW, ERR_UNDERFLOW);
         end
      end
   end

   initial begin
      int r;
      logic [2:0] op;
      // Reset state
      cyc("reset", 0, NOP, 0, 0, 1);
      cyc("reset", 0, NOP, 0, 0, 1);
      cyc("idle", 0, NOP, 0, 0, 0);
      // Three pushes; third spills 0x11 to RAM
      cyc("push11", 1, PUSH, 24'hAB0011, 0, 0);
      cyc("push22", 1, PUSH, 24'h000022, 0, 0);
      cyc("push33", 1, PUSH, 24'hFF0033, 0, 0);
      // POP with refill; PUSH during BUSY is dropped
      cyc("pop_refill", 1, POP, 0, 0, 0);
      cyc("push_busy", 1, PUSH, 24'h000099, 0, 0);
      cyc("after_refill", 0, NOP, 0, 0, 0);
      // REPLACE with refill
      cyc("reset2", 0, NOP, 0, 0, 1);
      cyc("push07", 1, PUSH, 24'h000007, 0, 0);
      cyc("push03", 1, PUSH, 24'h000003, 0, 0);
      cyc("push05", 1, PUSH, 24'h000005, 0, 0);
      cyc("replace", 1, REPL, 24'h000108, 0, 0);
      cyc("replace_nos", 0, NOP, 0, 0, 0);
      cyc("dup", 1, DUP, 0, 0, 0);
      cyc("replace_small", 1, REPL, 24'h0000C4, 0, 0);
      cyc("replace_nos2", 0, NOP, 0, 0, 0);
      // Underflow, clear, and set-beats-clear
      cyc("reset3", 0, NOP, 0, 0, 1);
      cyc("pop_empty", 1, POP, 0, 0, 0);
      cyc("clr_err", 0, NOP, 0, 1, 0);
      cyc("swap_empty_clr", 1, SWAP, 0, 1, 0);
      cyc("clr_err2", 0, NOP, 0, 1, 0);
      // Fill to DEPTH, overflow, SWAP at full
      for (int i = 0; i < DEPTH; i++) cyc("fill", 1, PUSH, UW'(i * 7 + 3), 0, 0);
      cyc("push_full", 1, PUSH, 24'h0000EE, 0, 0);
      cyc("swap_full", 1, SWAP, 0, 0, 0);
      // Reset in the middle of a refill
      cyc("pop_full", 1, POP, 0, 0, 0);
      cyc("rst_in_refill", 1, PUSH, 24'h000055, 0, 1);
      cyc("post_rst", 0, NOP, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 40)      op = ($urandom_range(0, 3) == 0) ? DUP : PUSH;
         else if (r < 60) op = POP;
         else if (r < 75) op = REPL;
         else if (r < 85) op = SWAP;
         else             op = 3'($urandom_range(0, 7));
         cyc("rand", $urandom_range(0, 9) != 0, op, UW'($urandom),
             !mbusy && ($urandom_range(0, 29) == 0), $urandom_range(0, 299) == 0);
      end
      cyc("drain", 0, NOP, 0, 0, 0);
      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
